updown_mod_counter: RTL and testbench
=====================================

UPDOWN_MOD_COUNTER -- requirements
Module: updown_mod_counter

Interface
REQ-001 SHALL have parameter WIDTH, default 4: bit width of the count value, legal 2..32.
REQ-002 SHALL have parameter MAX, default 15: upper count bound, legal 1..2^WIDTH-1; counting range is 0..MAX.
REQ-003 SHALL have parameter SATURATE, default 0: 0 means wrap at bounds, 1 means hold at bounds.
REQ-004 SHALL have parameter PRESCALE, default 1: enabled clocks per count step, legal 1..65535.
REQ-005 SHALL have port clk  input  1: the single clock; all state updates on its rising edge.
REQ-006 SHALL have port reset  input  1: synchronous, active-high reset.
REQ-007 SHALL have port en  input  1: count enable; when low, the prescaler and count hold.
REQ-008 SHALL have port up  input  1: direction; 1 counts up, 0 counts down.
REQ-009 SHALL have port load  input  1: synchronous load strobe.
REQ-010 SHALL have port load_val  input  WIDTH: value captured on load.
REQ-011 SHALL have port count  output  WIDTH: registered count value.
REQ-012 SHALL have port wrap  output  1: registered one-cycle pulse; count wrapped (SATURATE=0) or a step was blocked at a bound (SATURATE=1).
REQ-013 SHALL have port at_max  output  1: combinational, high when count == MAX.
REQ-014 SHALL have port at_zero  output  1: combinational, high when count == 0.

Function
REQ-015 SHALL apply priority per edge: reset > load > step > hold.
REQ-016 SHALL keep an internal prescaler counter pre in 0..PRESCALE-1; a step tick occurs on an edge where en=1, load=0 and pre==PRESCALE-1.
REQ-017 SHALL increment pre on each edge with en=1 and load=0, returning to 0 on the tick edge; with PRESCALE=1 every enabled edge is a tick.
REQ-018 SHALL clear pre to 0 on load and on reset; pre SHALL hold when en=0.
REQ-019 SHALL on a tick with up=1 set count to count+1 when count<MAX; at count==MAX set count to 0 (SATURATE=0) or hold at MAX (SATURATE=1).
REQ-020 SHALL on a tick with up=0 set count to count-1 when count>0; at count==0 set count to MAX (SATURATE=0) or hold at 0 (SATURATE=1).
REQ-021 SHALL on load set count to load_val when load_val<=MAX, else to MAX (clamp); load ignores en.
REQ-022 SHALL assert wrap for exactly the one cycle after a tick edge that hit a bound per REQ-019/020; wrap SHALL be 0 at all other times, including after load.
REQ-023 SHALL hold count constant with wrap=0 when en=0 or no tick occurs.
REQ-024 SHALL sample up only on tick edges; direction changes between ticks have no effect on pre.
REQ-025 SHALL never present a count value outside 0..MAX after the first clock edge following reset.
REQ-026 SHALL contain no combinational path from inputs to count or wrap.

Reset
REQ-027 SHALL, on any edge with reset=1, set count=0, pre=0, wrap=0 regardless of en, load and up.
REQ-028 SHALL, after reset, have at_zero=1 and at_max=0 (MAX>=1).
REQ-029 SHALL abort any partial prescale interval on reset mid-operation; the first tick after release occurs PRESCALE enabled edges later.

Verification
REQ-030 SHALL verify wrap up: defaults, reset, then en=1 up=1 for 16 edges -> count 1..15 then 0; wrap=1 only in the cycle count shows 0.
REQ-031 SHALL verify saturation down: SATURATE=1, MAX=9, load_val=2 load, then en=1 up=0 for 4 edges -> count 1,0,0,0; wrap=1 in the 2 cycles after the blocked steps.
REQ-032 SHALL verify prescale: PRESCALE=3, en=1 up=1 from reset -> count changes to 1 after 3rd edge and 2 after 6th; en=0 for 2 edges mid-interval extends the interval by 2.
REQ-033 SHALL verify load clamp and priority: WIDTH=4, MAX=9, load=1 load_val=13 with en=1 -> count=9, no wrap; next load=1 with reset=1 -> count=0.
REQ-034 SHALL verify down wrap to MAX: MAX=9, count=0, en=1 up=0 for 1 edge -> count=9, at_max=1, wrap=1 for one cycle.
REQ-035 SHALL verify reset mid-interval: PRESCALE=4, 2 enabled edges, reset 1 edge, then en=1 -> count stays 0 for 3 edges and becomes 1 on the 4th.

Source files
------------

// File: rtl/updown_mod_counter.sv
// Up/down modulo counter over 0..MAX with an optional prescaler and a choice
// of wrap or saturate at the bounds; wrap pulses when a step hits a bound.
module updown_mod_counter #(
    parameter int          WIDTH    = 4,
    parameter int unsigned MAX      = 15,
    parameter int          SATURATE = 0,
    parameter int          PRESCALE = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic             wrap,
    output logic             at_max,
    output logic             at_zero
);

    localparam int               PW       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0]    PRE_LAST = PW'(PRESCALE - 1);
    localparam logic [WIDTH-1:0] MAX_V    = WIDTH'(MAX);
    localparam bit               SAT      = (SATURATE != 0);

    logic [PW-1:0] pre;
    logic          tick;

    // A load restarts the prescale interval, so it also suppresses the tick.
    assign tick    = en && !load && (pre == PRE_LAST);
    assign at_max  = (count == MAX_V);
    assign at_zero = (count == '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
            pre   <= '0;
            wrap  <= 1'b0;
        end else begin
            wrap <= 1'b0;
            if (load) begin
                count <= (load_val > MAX_V) ? MAX_V : load_val;
                pre   <= '0;
            end else if (en) begin
                pre <= (pre == PRE_LAST) ? '0 : pre + 1'b1;
                if (tick) begin
                    if (up) begin
                        if (count >= MAX_V) begin
                            wrap  <= 1'b1;
                            count <= SAT ? MAX_V : '0;
                        end else begin
                            count <= count + 1'b1;
                        end
                    end else begin
                        if (count == '0) begin
                            wrap  <= 1'b1;
                            count <= SAT ? '0 : MAX_V;
                        end else begin
                            count <= count - 1'b1;
                        end
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_updown_mod_counter.sv
// Directed bench: five counter configurations share one stimulus stream; each
// directed step checks only the instance it targets.
module tb_updown_mod_counter;

    logic       clk = 1'b0;
    logic       reset, en, up, load;
    logic [3:0] load_val;

    logic [3:0] cnt_a, cnt_b, cnt_c, cnt_d, cnt_e;
    logic       wrp_a, wrp_b, wrp_c, wrp_d, wrp_e;
    logic       mx_a, mx_b, mx_c, mx_d, mx_e;
    logic       zr_a, zr_b, zr_c, zr_d, zr_e;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    // a: defaults; b: saturating MAX=9; c: wrapping MAX=9; d: PRESCALE=3; e: PRESCALE=4
    updown_mod_counter u_a (.clk(clk), .reset(reset), .en(en), .up(up), .load(load),
        .load_val(load_val), .count(cnt_a), .wrap(wrp_a), .at_max(mx_a), .at_zero(zr_a));
    updown_mod_counter #(.WIDTH(4), .MAX(9), .SATURATE(1)) u_b (.clk(clk), .reset(reset),
        .en(en), .up(up), .load(load), .load_val(load_val), .count(cnt_b), .wrap(wrp_b),
        .at_max(mx_b), .at_zero(zr_b));
    updown_mod_counter #(.WIDTH(4), .MAX(9), .SATURATE(0)) u_c (.clk(clk), .reset(reset),
        .en(en), .up(up), .load(load), .load_val(load_val), .count(cnt_c), .wrap(wrp_c),
        .at_max(mx_c), .at_zero(zr_c));
    updown_mod_counter #(.PRESCALE(3)) u_d (.clk(clk), .reset(reset), .en(en), .up(up),
        .load(load), .load_val(load_val), .count(cnt_d), .wrap(wrp_d), .at_max(mx_d),
        .at_zero(zr_d));
    updown_mod_counter #(.PRESCALE(4)) u_e (.clk(clk), .reset(reset), .en(en), .up(up),
        .load(load), .load_val(load_val), .count(cnt_e), .wrap(wrp_e), .at_max(mx_e),
        .at_zero(zr_e));

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    initial begin
        reset = 1'b1; en = 1'b0; up = 1'b1; load = 1'b0; load_val = 4'd0;
        step();
        check("rst_cnt_a", cnt_a, 0);
        check("rst_wrap_a", wrp_a, 0);
        check("rst_zero_a", zr_a, 1);
        check("rst_max_a", mx_a, 0);
        check("rst_cnt_d", cnt_d, 0);

        // Wrap up on defaults: 1..15 then 0, wrap only alongside the 0.
        reset = 1'b0; en = 1'b1; up = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            step();
            check($sformatf("up_cnt_%0d", i), cnt_a, i % 16);
            check($sformatf("up_wrap_%0d", i), wrp_a, (i == 16) ? 1 : 0);
            if (i == 15) check("up_atmax", mx_a, 1);
        end
        check("up_atzero", zr_a, 1);

        // Saturating down from a load of 2.
        reset = 1'b1; en = 1'b0; step();
        reset = 1'b0; load = 1'b1; load_val = 4'd2; step();
        check("sat_load", cnt_b, 2);
        check("sat_load_wrap", wrp_b, 0);
        load = 1'b0; en = 1'b1; up = 1'b0;
        step(); check("sat_c1", cnt_b, 1); check("sat_w1", wrp_b, 0);
        step(); check("sat_c2", cnt_b, 0); check("sat_w2", wrp_b, 0);
        step(); check("sat_c3", cnt_b, 0); check("sat_w3", wrp_b, 1);
        step(); check("sat_c4", cnt_b, 0); check("sat_w4", wrp_b, 1);
        en = 1'b0;
        step(); check("sat_idle_c", cnt_b, 0); check("sat_idle_w", wrp_b, 0);

        // Prescale by 3, with a two-edge enable gap mid-interval.
        reset = 1'b1; step();
        reset = 1'b0; en = 1'b1; up = 1'b1;
        step(); check("pre_e1", cnt_d, 0);
        step(); check("pre_e2", cnt_d, 0);
        step(); check("pre_e3", cnt_d, 1);
        step(); check("pre_e4", cnt_d, 1);
        step(); check("pre_e5", cnt_d, 1);
        step(); check("pre_e6", cnt_d, 2);
        step(); check("pre_e7", cnt_d, 2);
        en = 1'b0;
        step(); check("pre_e8", cnt_d, 2);
        step(); check("pre_e9", cnt_d, 2);
        en = 1'b1;
        step(); check("pre_e10", cnt_d, 2);
        step(); check("pre_e11", cnt_d, 3);
        check("pre_e11_wrap", wrp_d, 0);

        // Load clamp, then reset beats load.
        reset = 1'b1; step();
        reset = 1'b0; load = 1'b1; load_val = 4'd13; en = 1'b1; up = 1'b1;
        step();
        check("clamp_cnt", cnt_c, 9);
        check("clamp_wrap", wrp_c, 0);
        check("clamp_atmax", mx_c, 1);
        check("clamp_def_cnt", cnt_a, 13);
        reset = 1'b1;
        step();
        check("prio_cnt", cnt_c, 0);
        check("prio_wrap", wrp_c, 0);

        // Down from 0 wraps to MAX.
        reset = 1'b0; load = 1'b0; en = 1'b1; up = 1'b0;
        step();
        check("dwrap_cnt", cnt_c, 9);
        check("dwrap_atmax", mx_c, 1);
        check("dwrap_wrap", wrp_c, 1);
        check("dwrap_def_cnt", cnt_a, 15);
        en = 1'b0;
        step();
        check("dwrap_hold_cnt", cnt_c, 9);
        check("dwrap_hold_wrap", wrp_c, 0);

        // Reset mid-interval restarts the prescaler.
        reset = 1'b1; step();
        reset = 1'b0; en = 1'b1; up = 1'b1;
        step(); check("rmid_e1", cnt_e, 0);
        step(); check("rmid_e2", cnt_e, 0);
        reset = 1'b1;
        step(); check("rmid_rst", cnt_e, 0);
        reset = 1'b0;
        step(); check("rmid_a1", cnt_e, 0);
        step(); check("rmid_a2", cnt_e, 0);
        step(); check("rmid_a3", cnt_e, 0);
        step(); check("rmid_a4", cnt_e, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
